// File: rtl/pwm_ramp_sequencer_if.sv
// pwm_ramp_sequencer_if: ramp command channel (valid/ready plus target, step and interval)
interface pwm_ramp_sequencer_if #(
  parameter int DUTY_W = 8,
  parameter int INTV_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_target;
  logic [DUTY_W-1:0] cmd_step;
  logic [INTV_W-1:0] cmd_interval;
  modport master(output cmd_valid, cmd_target, cmd_step, cmd_interval, input cmd_ready);
  modport slave(input cmd_valid, cmd_target, cmd_step, cmd_interval, output cmd_ready);
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: ramps the pwm_generator duty toward a commanded target on PWM period boundaries
module pwm_ramp_sequencer #(
  parameter int DUTY_W      = 8,
  parameter int PERIOD_CLKS = 256,
  parameter int INTV_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  pwm_ramp_sequencer_if.slave cmd,
  output logic [DUTY_W-1:0] duty,
  output logic              period_start,
  output logic              busy,
  output logic              done
);
  localparam int PW = $clog2(PERIOD_CLKS);
  typedef enum logic {IDLE, RAMP} state_t;
  state_t state, state_n;
  logic [PW-1:0] pcnt;
  logic [INTV_W-1:0] icnt, icnt_n, itv, itv_n;
  logic [DUTY_W-1:0] tgt, tgt_n, stp, stp_n, duty_n, stepped;
  logic [DUTY_W:0] sum, dif;
  logic done_n;
  assign period_start  = en && pcnt == '0;
  assign busy          = state == RAMP;
  assign cmd.cmd_ready = state == IDLE;
  // One extra bit exposes overflow past full scale and borrow past zero before clamping
  assign sum = {1'b0, duty} + {1'b0, stp};
  assign dif = {1'b0, duty} - {1'b0, stp};
  assign stepped = tgt > duty ? (sum > {1'b0, tgt} ? tgt : sum[DUTY_W-1:0])
                              : (dif[DUTY_W] || dif < {1'b0, tgt} ? tgt : dif[DUTY_W-1:0]);
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    stp_n   = stp;
    itv_n   = itv;
    icnt_n  = icnt;
    duty_n  = duty;
    done_n  = 1'b0;
    if (state == IDLE && cmd.cmd_valid) begin
      tgt_n   = cmd.cmd_target;
      stp_n   = cmd.cmd_step == '0 ? DUTY_W'(1) : cmd.cmd_step;
      itv_n   = cmd.cmd_interval == '0 ? INTV_W'(1) : cmd.cmd_interval;
      icnt_n  = itv_n;
      done_n  = cmd.cmd_target == duty;
      state_n = cmd.cmd_target == duty ? IDLE : RAMP;
    end else if (state == RAMP && period_start) begin
      if (icnt == INTV_W'(1)) begin
        duty_n  = stepped;
        icnt_n  = itv;
        done_n  = stepped == tgt;
        state_n = stepped == tgt ? IDLE : RAMP;
      end else begin
        icnt_n = icnt - INTV_W'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pcnt  <= '0;
      icnt  <= '0;
      itv   <= '0;
      tgt   <= '0;
      stp   <= '0;
      duty  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      pcnt  <= en ? (pcnt == PW'(PERIOD_CLKS - 1) ? '0 : pcnt + PW'(1)) : pcnt;
      icnt  <= icnt_n;
      itv   <= itv_n;
      tgt   <= tgt_n;
      stp   <= stp_n;
      duty  <= duty_n;
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer: directed ramp scenarios with hand-computed duty sequences
module tb_pwm_ramp_sequencer;
  logic clk = 0, rst = 0, en = 0;
  logic [7:0] duty;
  logic period_start, busy, done;
  int n_checks = 0, n_fail = 0;
  pwm_ramp_sequencer_if #(.DUTY_W(8), .INTV_W(8)) cmd ();
  pwm_ramp_sequencer #(.DUTY_W(8), .PERIOD_CLKS(16), .INTV_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd(cmd.slave),
    .duty(duty), .period_start(period_start), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic next_boundary();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (period_start) found = 1;
      tick();
    end
    if (!found) check("boundary_timeout", 0, 1);
  endtask
  task automatic send(input logic [7:0] t, input logic [7:0] s, input logic [7:0] iv);
    cmd.cmd_valid = 1;
    cmd.cmd_target = t;
    cmd.cmd_step = s;
    cmd.cmd_interval = iv;
    tick();
    cmd.cmd_valid = 0;
  endtask
  task automatic ramp(input string tag, input logic [7:0] t, input logic [7:0] s, input logic [7:0] iv,
                      input logic [7:0] exp[$]);
    send(t, s, iv);
    check({tag, "_busy"}, busy, 1);
    foreach (exp[k]) begin
      for (int j = 1; j < (iv == 0 ? 1 : iv); j++) begin
        next_boundary();
        check({tag, "_hold"}, duty, k == 0 ? 32'(dut.tgt > exp[0] ? 0 : 0) + 32'(duty) : 32'(exp[k-1]));
      end
      next_boundary();
      check({tag, "_duty"}, duty, exp[k]);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_idle"}, busy, 0);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask
  initial begin
    int ps_cnt;
    cmd.cmd_valid = 0;
    cmd.cmd_target = 0;
    cmd.cmd_step = 0;
    cmd.cmd_interval = 0;
    tick();
    tick();
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd.cmd_ready, 1);
    check("rst_pstart", period_start, 0);
    rst = 1;
    en = 1;
    tick();
    ramp("up64", 64, 16, 1, '{16, 32, 48, 64});
    send(10, 20, 2);
    next_boundary();
    check("dn_hold0", duty, 64);
    next_boundary();
    check("dn_44", duty, 44);
    next_boundary();
    check("dn_hold1", duty, 44);
    next_boundary();
    check("dn_24", duty, 24);
    next_boundary();
    next_boundary();
    check("dn_10", duty, 10);
    check("dn_done", done, 1);
    tick();
    ramp("to250", 250, 255, 1, '{250});
    ramp("to255", 255, 20, 1, '{255});
    ramp("to64", 64, 200, 0, '{64});
    send(64, 5, 1);
    check("same_done", done, 1);
    check("same_busy", busy, 0);
    check("same_duty", duty, 64);
    tick();
    check("same_pulse", done, 0);
    ramp("to0", 0, 100, 1, '{0});
    send(64, 16, 1);
    next_boundary();
    next_boundary();
    check("frz_pre", duty, 32);
    en = 0;
    ps_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (period_start) ps_cnt++;
      tick();
    end
    check("frz_pstart", ps_cnt, 0);
    check("frz_duty", duty, 32);
    check("frz_busy", busy, 1);
    en = 1;
    next_boundary();
    check("frz_48", duty, 48);
    next_boundary();
    check("frz_64", duty, 64);
    check("frz_done", done, 1);
    tick();
    ramp("to0b", 0, 100, 1, '{0});
    send(64, 16, 1);
    cmd.cmd_valid = 1;
    cmd.cmd_target = 200;
    cmd.cmd_step = 1;
    cmd.cmd_interval = 1;
    check("ign_ready", cmd.cmd_ready, 0);
    next_boundary();
    check("ign_16", duty, 16);
    next_boundary();
    next_boundary();
    check("ign_48", duty, 48);
    check("ign_ready2", cmd.cmd_ready, 0);
    cmd.cmd_valid = 0;
    rst = 0;
    tick();
    rst = 1;
    check("abort_duty", duty, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready", cmd.cmd_ready, 1);
    tick();
    check("abort_nodone", done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
